midori64_batch_feeder: RTL and testbench
========================================

# midori64_batch_feeder

Host-side feeder and collector for the 3-share Midori64 core. It accepts unmasked plaintext blocks and a key over valid/ready, splits them into three Boolean shares with fresh randomness, and streams a 4-block batch into the core while holding the core in reset. It then releases the core and captures the 4 consecutive share-triples the core emits after `done`. Finally it recombines them and returns the unmasked results to the host over valid/ready.

## Interface
- `SLOTS`, 4: blocks per batch. Fixed by the core's 4-way interleave; other values are not supported.
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `pt_in`  in  64  plaintext/ciphertext block from host
- `pt_last`  in  1  marks the final block of a batch; qualified by `pt_valid`
- `pt_valid` / `pt_ready`  in / out  1  host input handshake
- `key_in`  in  128  unmasked key; sampled with the first block of a batch
- `enc_dec_in`  in  1  0 = encrypt, 1 = decrypt; sampled with the first block
- `rnd_in`  in  128  fresh randomness, valid every cycle
- `ct_out`  out  64  recombined result
- `ct_valid` / `ct_ready`  out / in  1  host output handshake
- `core_reset`  out  1  drives the core's `reset`
- `core_input1..3`  out  64 each  plaintext shares
- `core_Key1..3`  out  128 each  key shares
- `core_r`  out  128  fresh randomness to the core
- `core_enc_dec`  out  1
- `core_output1..3`  in  64 each  core output shares
- `core_done`  in  1

## Operation
- **FSM states:** COLLECT, LOAD, RUN, CAPTURE, DRAIN.
- **COLLECT**
  - `pt_ready` = 1. Each handshake writes `pt_in` into `buf[cnt]` and sets `vld[cnt]` = 1, then increments `cnt`.
  - On the first handshake of a batch, latch `key_in` and `enc_dec_in`.
  - Leave COLLECT after the handshake where `cnt` = 3 or `pt_last` = 1.
  - On exit, unfilled slots get `buf` = 0 and `vld` = 0. They are still encrypted but their results are dropped.
- **LOAD** (exactly 4 cycles, k = 0..3)
  - `core_reset` = 1.
  - `core_input2 = rnd_in[63:0]`, `core_input3 = rnd_in[127:64]`, `core_input1 = buf[k] ^ core_input2 ^ core_input3`. All three are registered, so values are stable for the whole cycle k.
- **Key shares**
  - Drawn once per batch on LOAD entry: `Key2` and `Key3` from two consecutive `rnd_in` samples, `Key1 = key ^ Key2 ^ Key3`.
  - Held constant from the first LOAD cycle to the end of CAPTURE.
- **`core_r`** = `rnd_in`, registered every cycle.
- **RUN:** `core_reset` = 0. Wait for `core_done` = 1.
- **CAPTURE**
  - Entered in the first cycle `core_done` = 1.
  - On that cycle and the next 3, store `res[j] = core_output1 ^ core_output2 ^ core_output3`, j = 0..3. `res[j]` corresponds to `buf[j]`.
  - `core_reset` stays 0 throughout.
- **DRAIN**
  - `core_reset` = 1.
  - Present `res[j]` for each j with `vld[j]` = 1, in ascending j, using a skip-invalid pointer.
  - Return to COLLECT after the last valid slot's handshake. If no slot is valid, return immediately.
- `core_reset` = 0 only in RUN and CAPTURE.

## Timing
- **Reset values:** state = COLLECT, `cnt` = 0, all `vld` = 0, `core_reset` = 1, `pt_ready` = 0 in the reset cycle and 1 afterwards, `ct_valid` = 0, all core data outputs = 0, `ct_out` = 0.
- **Reset mid-operation:** any state returns to COLLECT with the above values next cycle. Buffered blocks and results are discarded. `core_reset` is reasserted.
- **Load timing:** the core samples slot k on the rising edge ending LOAD cycle k. `core_reset` falls on the edge ending LOAD cycle 3, so RUN starts the cycle after the fourth load.
- **Latency:** first `ct_valid` one cycle after the last CAPTURE cycle.
- **Output handshake:** `ct_out` is stable while `ct_valid` = 1 and `ct_ready` = 0. Back-to-back transfers run at 1 per cycle.
- **Input handshake:** `pt_ready` = 0 outside COLLECT. There is no overlap between batches.
- `pt_last` together with the 4th block ends the batch normally. `pt_last` on an earlier block leaves the remaining slots as dummies.
- `core_done` high on entry to RUN counts immediately. There is no minimum RUN length.

## Test plan
- **Full batch encrypt:** key 687ded3b3c85b3f35b1009863e2a8cbf, blocks 0, 42c20fd3b586879e, 0, 42c20fd3b586879e, `enc_dec` = 0 → `ct_out` 36f32dcf124ab057, 66bcdc6270d901cd, 36f32dcf124ab057, 66bcdc6270d901cd in order. Check that `core_input1^2^3` matches each block during LOAD and that the shares change with `rnd_in`.
- **Partial batch:** a single block 42c20fd3b586879e with `pt_last` = 1 → exactly one `ct_valid` transfer, 66bcdc6270d901cd, then `pt_ready` = 1 again.
- **Decrypt:** same key, block 66bcdc6270d901cd, `enc_dec` = 1, `pt_last` = 1 → 42c20fd3b586879e.
- **Backpressure:** full batch from the first scenario with `ct_ready` toggled pseudo-randomly → identical four results in order, with no loss or duplication and `ct_out` stable while stalled.
- **Reset mid-RUN:** assert `reset` during RUN → next cycle state COLLECT, `core_reset` = 1, `ct_valid` = 0. A following full batch yields correct results.
- **Randomness independence:** repeat the first scenario with `rnd_in` held at 0 and then with random values → identical `ct_out` sequences.

Source files
------------

// File: rtl/midori64_batch_feeder.sv
// midori64_batch_feeder
// Host-side feeder/collector around a 3-share Midori64 core.
// Collects up to SLOTS plaintext blocks, masks them into three Boolean
// shares with fresh randomness, loads them into the core while it is held
// in reset, releases it, captures the SLOTS share-triples that follow
// core_done, recombines them, and drains the valid results to the host.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   pt_in/pt_last         : host block and end-of-batch marker
//   pt_valid/pt_ready     : host input handshake
//   key_in, enc_dec_in    : key and direction, taken with the first block
//   rnd_in                : fresh randomness, every cycle
//   ct_out/ct_valid/ct_ready : recombined result handshake
//   core_*                : shares, randomness and control to/from the core
module midori64_batch_feeder #(
  parameter int SLOTS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  pt_in,
  input  logic         pt_last,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] key_in,
  input  logic         enc_dec_in,
  input  logic [127:0] rnd_in,
  output logic [63:0]  ct_out,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         core_reset,
  output logic [63:0]  core_input1,
  output logic [63:0]  core_input2,
  output logic [63:0]  core_input3,
  output logic [127:0] core_Key1,
  output logic [127:0] core_Key2,
  output logic [127:0] core_Key3,
  output logic [127:0] core_r,
  output logic         core_enc_dec,
  input  logic [63:0]  core_output1,
  input  logic [63:0]  core_output2,
  input  logic [63:0]  core_output3,
  input  logic         core_done
);

  localparam int IW = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST = IW'(SLOTS - 1);

  typedef enum logic [2:0] {COLLECT, LOAD, RUN, CAPTURE, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            cnt_q, cnt_d;
  // slot index: load slot in LOAD, capture slot in RUN/CAPTURE, drain pointer in DRAIN
  logic [IW-1:0]            idx_q, idx_d;
  logic [SLOTS-1:0][63:0]   blk_q, blk_d;
  logic [SLOTS-1:0]         vld_q, vld_d;
  logic [SLOTS-1:0][63:0]   res_q, res_d;
  logic [127:0]             key_q, key_d;
  logic                     ed_q, ed_d;
  logic                     core_reset_q, core_reset_d;
  logic [63:0]              in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
  logic [127:0]             k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [127:0]             r_q;

  logic                     load_en;
  logic [IW-1:0]            load_slot;
  logic [IW:0]              nxt_from;
  logic                     nxt_found;
  logic [IW-1:0]            nxt_idx;
  logic [63:0]              out_x;

  assign out_x        = core_output1 ^ core_output2 ^ core_output3;
  assign core_reset   = core_reset_q;
  assign core_input1  = in1_q;
  assign core_input2  = in2_q;
  assign core_input3  = in3_q;
  assign core_Key1    = k1_q;
  assign core_Key2    = k2_q;
  assign core_Key3    = k3_q;
  assign core_r       = r_q;
  assign core_enc_dec = ed_q;

  assign pt_ready = (state_q == COLLECT) && !reset;
  assign ct_valid = (state_q == DRAIN) && vld_q[idx_q];
  assign ct_out   = ct_valid ? res_q[idx_q] : '0;

  // Lowest valid slot at or above nxt_from (from 0 when entering DRAIN,
  // from pointer+1 when advancing inside DRAIN).
  always_comb begin
    nxt_from  = (state_q == DRAIN) ? ({1'b0, idx_q} + 1'b1) : '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (vld_q[i] && i >= int'(nxt_from)) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    vld_d        = vld_q;
    res_d        = res_q;
    key_d        = key_q;
    ed_d         = ed_q;
    core_reset_d = core_reset_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    in3_d        = in3_q;
    k1_d         = k1_q;
    k2_d         = k2_q;
    k3_d         = k3_q;
    load_en      = 1'b0;
    load_slot    = '0;

    unique case (state_q)
      COLLECT: begin
        if (pt_valid) begin
          blk_d[cnt_q] = pt_in;
          vld_d[cnt_q] = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            key_d = key_in;
            ed_d  = enc_dec_in;
          end
          if (cnt_q == LAST || pt_last) begin
            // unfilled slots become zero dummies whose results are dropped
            for (int i = 0; i < SLOTS; i++) begin
              if (i > int'(cnt_q)) begin
                blk_d[i] = '0;
                vld_d[i] = 1'b0;
              end
            end
            cnt_d     = '0;
            idx_d     = '0;
            state_d   = LOAD;
            load_en   = 1'b1;
            load_slot = '0;
            // key shares from two consecutive rnd_in samples
            k2_d = r_q;
            k3_d = rnd_in;
            k1_d = key_d ^ r_q ^ rnd_in;
          end
        end
      end
      LOAD: begin
        if (idx_q == LAST) begin
          state_d      = RUN;
          core_reset_d = 1'b0;
          idx_d        = '0;
        end else begin
          idx_d     = idx_q + 1'b1;
          load_en   = 1'b1;
          load_slot = idx_q + 1'b1;
        end
      end
      RUN: begin
        // the first done cycle is already capture slot 0
        if (core_done) begin
          res_d[0] = out_x;
          idx_d    = IW'(1);
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        res_d[idx_q] = out_x;
        if (idx_q == LAST) begin
          core_reset_d = 1'b1;
          idx_d        = nxt_idx;
          state_d      = nxt_found ? DRAIN : COLLECT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!vld_q[idx_q]) begin
          state_d = COLLECT;
          idx_d   = '0;
        end else if (ct_ready) begin
          if (nxt_found) begin
            idx_d = nxt_idx;
          end else begin
            state_d = COLLECT;
            idx_d   = '0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // shares are registered so they hold for the whole load cycle
    if (load_en) begin
      in2_d = rnd_in[63:0];
      in3_d = rnd_in[127:64];
      in1_d = blk_d[load_slot] ^ rnd_in[63:0] ^ rnd_in[127:64];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_q        <= '0;
      vld_q        <= '0;
      res_q        <= '0;
      key_q        <= '0;
      ed_q         <= 1'b0;
      core_reset_q <= 1'b1;
      in1_q        <= '0;
      in2_q        <= '0;
      in3_q        <= '0;
      k1_q         <= '0;
      k2_q         <= '0;
      k3_q         <= '0;
      r_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
      vld_q        <= vld_d;
      res_q        <= res_d;
      key_q        <= key_d;
      ed_q         <= ed_d;
      core_reset_q <= core_reset_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      in3_q        <= in3_d;
      k1_q         <= k1_d;
      k2_q         <= k2_d;
      k3_q         <= k3_d;
      r_q          <= rnd_in;
    end
  end

endmodule

// File: tb/tb_midori64_batch_feeder.sv
// Bench for midori64_batch_feeder: a behavioural 3-share core stand-in
// (plain Midori64 on recombined shares) plus host-side batch scenarios.
module tb_midori64_batch_feeder;

  logic         clk;
  logic         reset;
  logic [63:0]  pt_in;
  logic         pt_last, pt_valid, pt_ready;
  logic [127:0] key_in;
  logic         enc_dec_in;
  logic [127:0] rnd_in;
  logic [63:0]  ct_out;
  logic         ct_valid, ct_ready;
  logic         core_reset;
  logic [63:0]  core_input1, core_input2, core_input3;
  logic [127:0] core_Key1, core_Key2, core_Key3, core_r;
  logic         core_enc_dec;
  logic [63:0]  core_output1, core_output2, core_output3;
  logic         core_done;

  midori64_batch_feeder #(.SLOTS(4)) dut (
    .clk(clk), .reset(reset),
    .pt_in(pt_in), .pt_last(pt_last), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .key_in(key_in), .enc_dec_in(enc_dec_in), .rnd_in(rnd_in),
    .ct_out(ct_out), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .core_reset(core_reset),
    .core_input1(core_input1), .core_input2(core_input2), .core_input3(core_input3),
    .core_Key1(core_Key1), .core_Key2(core_Key2), .core_Key3(core_Key3),
    .core_r(core_r), .core_enc_dec(core_enc_dec),
    .core_output1(core_output1), .core_output2(core_output2), .core_output3(core_output3),
    .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- Midori64 reference ----------------
  localparam logic [63:0] SB   = 64'hcad3ebf789150246;
  localparam logic [63:0] PERM = 64'h0a5fe4b193c67d28;
  localparam logic [15:0] RC [15] = '{16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
                                      16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
                                      16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90};

  function automatic logic [63:0] f_sub(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[63-4*i -: 4] = SB[63-4*int'(s[63-4*i -: 4]) -: 4];
    return r;
  endfunction

  function automatic logic [63:0] f_shuf(input logic [63:0] s);
    logic [63:0] r;
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = s[63-4*int'(PERM[63-4*j -: 4]) -: 4];
    return r;
  endfunction

  function automatic logic [63:0] f_ishuf(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[63-4*int'(PERM[63-4*j -: 4]) -: 4] = s[63-4*j -: 4];
    return r;
  endfunction

  function automatic logic [63:0] f_mix(input logic [63:0] s);
    logic [63:0] r;
    logic [3:0]  t;
    for (int c = 0; c < 4; c++) begin
      t = s[63-16*c -: 4] ^ s[59-16*c -: 4] ^ s[55-16*c -: 4] ^ s[51-16*c -: 4];
      for (int k = 0; k < 4; k++) r[63-16*c-4*k -: 4] = t ^ s[63-16*c-4*k -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] f_rk(input int i, input logic [127:0] k);
    logic [63:0] r;
    r = (i % 2 == 0) ? k[127:64] : k[63:0];
    for (int j = 0; j < 16; j++) r[60-4*j] = r[60-4*j] ^ RC[i][15-j];
    return r;
  endfunction

  function automatic logic [63:0] midori(input logic [63:0] x, input logic [127:0] k, input logic dec);
    logic [63:0] wk, s;
    wk = k[127:64] ^ k[63:0];
    s  = x ^ wk;
    if (!dec) begin
      for (int i = 0; i < 15; i++) s = f_mix(f_shuf(f_sub(s))) ^ f_rk(i, k);
      s = f_sub(s);
    end else begin
      s = f_sub(s);
      for (int i = 14; i >= 0; i--) s = f_sub(f_ishuf(f_mix(s ^ f_rk(i, k))));
    end
    return s ^ wk;
  endfunction

  // ---------------- core stand-in ----------------
  // Keeps the last four samples taken while core_reset is high; after
  // release it raises done after lat cycles and emits re-masked results.
  logic [63:0]  lpt  [4];
  logic [127:0] lkey [4];
  logic [63:0]  lres [4];
  logic         lshr [4];
  logic [127:0] prev_rnd = '0;
  logic [63:0]  m1 = '0, m2 = '0;
  int           ph = 0, lat = 0, lat_force = -1, mj;
  logic         rnd_zero = 1'b0;

  always @(negedge clk) rnd_in = rnd_zero ? '0 : {$urandom, $urandom, $urandom, $urandom};

  always @(posedge clk) begin
    prev_rnd <= rnd_in;
    m1 <= {$urandom, $urandom};
    m2 <= {$urandom, $urandom};
    if (core_reset) begin
      for (int i = 0; i < 3; i++) begin
        lpt[i] <= lpt[i+1]; lkey[i] <= lkey[i+1]; lres[i] <= lres[i+1]; lshr[i] <= lshr[i+1];
      end
      lpt[3]  <= core_input1 ^ core_input2 ^ core_input3;
      lkey[3] <= core_Key1 ^ core_Key2 ^ core_Key3;
      lres[3] <= midori(core_input1 ^ core_input2 ^ core_input3,
                        core_Key1 ^ core_Key2 ^ core_Key3, core_enc_dec);
      lshr[3] <= (core_input2 === prev_rnd[63:0]) && (core_input3 === prev_rnd[127:64]);
      ph  <= 0;
      lat <= (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
    end else begin
      ph <= ph + 1;
    end
  end

  always_comb begin
    mj = ph - lat;
    core_done    = !core_reset && (ph >= lat);
    core_output1 = '0;
    core_output2 = '0;
    core_output3 = '0;
    if (core_done && mj >= 0 && mj < 4) begin
      core_output2 = m1;
      core_output3 = m2;
      core_output1 = lres[mj] ^ m1 ^ m2;
    end
  end

  // ---------------- host side ----------------
  localparam logic [127:0] KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
  localparam logic [63:0]  PA  = 64'h42c20fd3b586879e;
  localparam logic [63:0]  CA  = 64'h66bcdc6270d901cd;
  localparam logic [63:0]  C0  = 64'h36f32dcf124ab057;

  logic [63:0]  tb_blk [4];
  logic [63:0]  tb_exp [4];
  logic [63:0]  tb_got [4];
  logic [63:0]  run1   [4];
  int           tb_n;
  logic [127:0] tb_key;
  logic         tb_ed;
  logic         tb_last4;

  task automatic send_batch();
    int w;
    for (int i = 0; i < tb_n; i++) begin
      @(negedge clk);
      pt_valid   = 1'b1;
      pt_in      = tb_blk[i];
      pt_last    = (i == tb_n - 1) && (tb_n < 4 || tb_last4);
      // only the first block's key/direction may be used
      key_in     = (i == 0) ? tb_key : ~tb_key;
      enc_dec_in = (i == 0) ? tb_ed : ~tb_ed;
      w = 0;
      while (pt_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) begin
        total++; bad++;
        $display("FAIL send_timeout: block %0d pt_ready=%b want 1", i, pt_ready);
      end
    end
    @(negedge clk);
    pt_valid = 1'b0;
    pt_last  = 1'b0;
    total++;
    if (pt_ready !== 1'b0) begin
      bad++; $display("FAIL ready_in_load: got %b want 0", pt_ready);
    end
  endtask

  task automatic check_load();
    int w;
    logic [63:0] e;
    w = 0;
    while (core_reset !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    total++;
    if (w >= 100) begin
      bad++; $display("FAIL run_timeout: core_reset=%b want 0", core_reset);
    end
    for (int i = 0; i < 4; i++) begin
      e = (i < tb_n) ? tb_blk[i] : 64'h0;
      total++;
      if (lpt[i] !== e) begin bad++; $display("FAIL load_share_xor[%0d]: got %h want %h", i, lpt[i], e); end
      total++;
      if (lkey[i] !== tb_key) begin bad++; $display("FAIL key_share_xor[%0d]: got %h want %h", i, lkey[i], tb_key); end
      total++;
      if (lshr[i] !== 1'b1) begin bad++; $display("FAIL share_fresh[%0d]: got %b want 1", i, lshr[i]); end
    end
    total++;
    if (core_enc_dec !== tb_ed) begin bad++; $display("FAIL enc_dec: got %b want %b", core_enc_dec, tb_ed); end
  endtask

  task automatic recv(input logic bp);
    int got, to;
    logic hold_v;
    logic [63:0] hold_d;
    got = 0; to = 0; hold_v = 1'b0; hold_d = '0;
    while (got < tb_n && to < 300) begin
      @(negedge clk);
      to++;
      if (hold_v) begin
        total++;
        if (ct_valid !== 1'b1 || ct_out !== hold_d) begin
          bad++; $display("FAIL stall_stable: got v=%b %h want v=1 %h", ct_valid, ct_out, hold_d);
        end
      end
      ct_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hold_v   = 1'b0;
      if (ct_valid === 1'b1) begin
        if (ct_ready) begin
          total++;
          if (ct_out !== tb_exp[got]) begin
            bad++; $display("FAIL result[%0d]: got %h want %h", got, ct_out, tb_exp[got]);
          end
          tb_got[got] = ct_out;
          got++;
        end else begin
          hold_v = 1'b1;
          hold_d = ct_out;
        end
      end
    end
    total++;
    if (got < tb_n) begin bad++; $display("FAIL recv_timeout: got %0d results want %0d", got, tb_n); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ct_ready = 1'b1;
      total++;
      if (ct_valid !== 1'b0 || pt_ready !== 1'b1) begin
        bad++; $display("FAIL after_drain: got valid=%b ready=%b want 0/1", ct_valid, pt_ready);
      end
    end
    ct_ready = 1'b0;
  endtask

  task automatic set_full();
    tb_n = 4; tb_key = KEY; tb_ed = 1'b0; tb_last4 = 1'b1;
    tb_blk[0] = 64'h0; tb_blk[1] = PA; tb_blk[2] = 64'h0; tb_blk[3] = PA;
    tb_exp[0] = C0;    tb_exp[1] = CA; tb_exp[2] = C0;    tb_exp[3] = CA;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (pt_ready !== 1'b0) begin bad++; $display("FAIL rst_pt_ready: got %b want 0", pt_ready); end
    total++;
    if (core_reset !== 1'b1 || ct_valid !== 1'b0 || ct_out !== 64'h0) begin
      bad++; $display("FAIL rst_outputs: got cr=%b v=%b ct=%h want 1 0 0", core_reset, ct_valid, ct_out);
    end
    total++;
    if ((core_input1 | core_input2 | core_input3) !== 64'h0 ||
        (core_Key1 | core_Key2 | core_Key3 | core_r) !== 128'h0 || core_enc_dec !== 1'b0) begin
      bad++; $display("FAIL rst_core_data: got in1=%h key1=%h r=%h want 0", core_input1, core_Key1, core_r);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (pt_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", pt_ready); end
  endtask

  task automatic test_full_batch();
    set_full();
    send_batch(); check_load(); recv(1'b0);
  endtask

  task automatic test_partial();
    tb_n = 1; tb_key = KEY; tb_ed = 1'b0; tb_last4 = 1'b0;
    tb_blk[0] = PA; tb_exp[0] = CA;
    send_batch(); check_load(); recv(1'b0);
  endtask

  task automatic test_decrypt();
    tb_n = 1; tb_key = KEY; tb_ed = 1'b1; tb_last4 = 1'b0;
    tb_blk[0] = CA; tb_exp[0] = PA;
    send_batch(); check_load(); recv(1'b0);
  endtask

  task automatic test_backpressure();
    set_full();
    send_batch(); check_load(); recv(1'b1);
  endtask

  task automatic test_reset_mid_run();
    set_full();
    lat_force = 20;
    send_batch(); check_load();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (core_reset !== 1'b1 || ct_valid !== 1'b0 || pt_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst: got cr=%b v=%b rdy=%b want 1 0 0", core_reset, ct_valid, pt_ready);
    end
    reset = 1'b0;
    lat_force = -1;
    @(negedge clk);
    total++;
    if (pt_ready !== 1'b1 || core_reset !== 1'b1) begin
      bad++; $display("FAIL mid_rst_collect: got rdy=%b cr=%b want 1 1", pt_ready, core_reset);
    end
    set_full();
    send_batch(); check_load(); recv(1'b0);
  endtask

  task automatic test_rnd_independence();
    set_full();
    rnd_zero = 1'b1;
    send_batch(); check_load(); recv(1'b0);
    for (int i = 0; i < 4; i++) run1[i] = tb_got[i];
    rnd_zero = 1'b0;
    send_batch(); check_load(); recv(1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tb_got[i] !== run1[i]) begin
        bad++; $display("FAIL rnd_indep[%0d]: got %h want %h", i, tb_got[i], run1[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      tb_n     = $urandom_range(1, 4);
      tb_key   = {$urandom, $urandom, $urandom, $urandom};
      tb_ed    = 1'($urandom_range(0, 1));
      tb_last4 = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        tb_blk[i] = {$urandom, $urandom};
        tb_exp[i] = midori(tb_blk[i], tb_key, tb_ed);
      end
      send_batch(); check_load(); recv(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; pt_in = '0; pt_last = 1'b0; pt_valid = 1'b0;
    key_in = '0; enc_dec_in = 1'b0; ct_ready = 1'b0;
    test_reset();
    test_full_batch();
    test_partial();
    test_decrypt();
    test_backpressure();
    test_reset_mid_run();
    test_rnd_independence();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
